// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizes for the register-file read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;
    // The RF index inputs are always 32 bits wide regardless of AW.
    localparam int RF_IDX_W  = 32;

endpackage

// File: rtl/regfile_read_arbiter_rr.sv
// Round-robin pick: lowest requesting index at or above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    // Scan NREQ slots starting at ptr; the first requesting slot wins.
    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the RF's two read ports among NREQ requesters with round-robin arbitration.
// Latency: accept at edge E0, rsp_valid after E1, earliest response handshake at E2.
// Backpressure: rsp_ready low holds RESP with stable outputs and blocks new grants.
module regfile_read_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int AW   = AW_DEF,
    parameter  int DW   = DW_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*AW-1:0]  req_rs1,
    input  logic [NREQ*AW-1:0]  req_rs2,
    output logic [RF_IDX_W-1:0] rf_read_register1,
    output logic [RF_IDX_W-1:0] rf_read_register2,
    input  logic [DW-1:0]       rf_read_data1,
    input  logic [DW-1:0]       rf_read_data2,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [DW-1:0]       rsp_data1,
    output logic [DW-1:0]       rsp_data2
);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            can_accept;
    logic [AW-1:0]   sel_rs1;
    logic [AW-1:0]   sel_rs2;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is offered only when the index registers are free to be reloaded.
    always_comb begin
        grant_any  = |grant;
        can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
        req_ready  = (can_accept && !reset) ? grant : '0;
        sel_rs1    = req_rs1[int'(grant_idx)*AW +: AW];
        sel_rs2    = req_rs2[int'(grant_idx)*AW +: AW];
    end

    // The RF output register tracks the held addresses, so data passes straight through.
    assign rsp_data1 = rf_read_data1;
    assign rsp_data2 = rf_read_data2;

    // Control FSM: latch winner indices, wait one RF edge, then hold the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            rf_read_register1 <= '0;
            rf_read_register2 <= '0;
            rsp_valid         <= 1'b0;
            rsp_id            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        rf_read_register1 <= RF_IDX_W'(sel_rs1);
                        rf_read_register2 <= RF_IDX_W'(sel_rs2);
                        rsp_id            <= grant_idx;
                        rr_ptr            <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                        state             <= READ;
                    end
                end
                READ: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (grant_any) begin
                            rf_read_register1 <= RF_IDX_W'(sel_rs1);
                            rf_read_register2 <= RF_IDX_W'(sel_rs2);
                            rsp_id            <= grant_idx;
                            rr_ptr            <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                            state             <= READ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a small registered RF model.
// Latency: checks exact E0/E1/E2 timing of grant and response.
// Backpressure: exercises rsp_ready stalls and back-to-back grants.
module tb_regfile_read_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_rs1;
    logic [NREQ*AW-1:0]  req_rs2;
    logic [31:0]         rf_read_register1;
    logic [31:0]         rf_read_register2;
    logic [DW-1:0]       rf_read_data1;
    logic [DW-1:0]       rf_read_data2;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [DW-1:0]       rsp_data1;
    logic [DW-1:0]       rsp_data2;

    int n_checks;
    int n_fail;

    regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_rs1           (req_rs1),
        .req_rs2           (req_rs2),
        .rf_read_register1 (rf_read_register1),
        .rf_read_register2 (rf_read_register2),
        .rf_read_data1     (rf_read_data1),
        .rf_read_data2     (rf_read_data2),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_data1         (rsp_data1),
        .rsp_data2         (rsp_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file contents used by the tests (only these indices are read).
    function automatic logic [31:0] rf_val(input logic [4:0] idx);
        case (idx)
            5'd5:    return 32'h5555_5555;
            5'd10:   return 32'hAAAA_AAAA;
            5'd15:   return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // RF read ports register the data on the clock edge; reset-state output is 0.
    initial begin
        rf_read_data1 = '0;
        rf_read_data2 = '0;
    end
    always @(posedge clk) begin
        rf_read_data1 <= rf_val(rf_read_register1[4:0]);
        rf_read_data2 <= rf_val(rf_read_register2[4:0]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] pk(input logic [4:0] a0, input logic [4:0] a1,
                                       input logic [4:0] a2, input logic [4:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [19:0] rs1;
        logic [19:0] rs2;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_id;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
    } vec_t;

    vec_t vecs[6];

    // One full transaction from IDLE; caller is at posedge+1.
    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        req_valid = v.valid;
        req_rs1   = v.rs1;
        req_rs2   = v.rs2;
        rsp_ready = 1'b0;
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(v.exp_grant));
        @(posedge clk); #1;
        req_valid = '0;
        check({tag, "_e1_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_read_ready"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(v.exp_id));
        check({tag, "_data1"}, rsp_data1, v.exp_d1);
        check({tag, "_data2"}, rsp_data2, v.exp_d2);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_post_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] lane_d1[4];
    logic [31:0] lane_d2[4];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        rsp_ready = 1'b0;

        // Vectors assume rr_ptr=0 after reset and walk the pointer: 0 ->3 ->1 ->2 ->0 ->2 ->1
        vecs[0] = '{4'b0100, pk(0, 0, 5, 0),   pk(0, 0, 10, 0), 4'b0100, 2'd2, 32'h5555_5555, 32'hAAAA_AAAA};
        vecs[1] = '{4'b0001, pk(0, 0, 0, 0),   pk(31, 0, 0, 0), 4'b0001, 2'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{4'b0010, pk(0, 15, 0, 0),  pk(0, 5, 0, 0),  4'b0010, 2'd1, 32'hFFFF_FFFF, 32'h5555_5555};
        vecs[3] = '{4'b1011, pk(5, 5, 0, 10),  pk(5, 5, 0, 15), 4'b1000, 2'd3, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
        vecs[4] = '{4'b1010, pk(0, 5, 0, 15),  pk(0, 0, 0, 15), 4'b0010, 2'd1, 32'h5555_5555, 32'h0000_0000};
        vecs[5] = '{4'b0011, pk(31, 5, 0, 0),  pk(10, 5, 0, 0), 4'b0001, 2'd0, 32'h0000_0000, 32'hAAAA_AAAA};

        lane_d1 = '{32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0000_0000};
        lane_d2 = '{32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0000_0000, 32'h5555_5555};

        // Reset state
        do_reset();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rf_reg1", rf_read_register1, 32'd0);
        check("rst_rf_reg2", rf_read_register2, 32'd0);

        // Table vectors
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // All four valid with rsp_ready held: grants 0,1,2,3,0 every two cycles
        do_reset();
        req_rs1   = pk(5, 10, 15, 31);
        req_rs2   = pk(10, 15, 0, 5);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        check("rr_first_grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        check("rr_read_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'(k % 4));
            check($sformatf("rr%0d_data1", k), rsp_data1, lane_d1[k % 4]);
            check($sformatf("rr%0d_data2", k), rsp_data2, lane_d2[k % 4]);
            if (k == 4) begin
                req_valid = '0;
                #1;
                check("rr_last_ready", 32'(req_ready), 32'd0);
                @(posedge clk); #1;
                check("rr_idle_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                check($sformatf("rr%0d_next_grant", k), 32'(req_ready), 32'(1 << ((k + 1) % 4)));
                @(posedge clk); #1;
                check($sformatf("rr%0d_gap", k), 32'(rsp_valid), 32'd0);
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b0;

        // Stall in RESP for 5 cycles, then release with a pending request
        do_reset();
        req_rs1   = pk(15, 10, 0, 0);
        req_rs2   = pk(5, 15, 0, 0);
        req_valid = 4'b0011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("stall%0d_rsp_id", c), 32'(rsp_id), 32'd0);
            check($sformatf("stall%0d_data1", c), rsp_data1, 32'hFFFF_FFFF);
            check($sformatf("stall%0d_data2", c), rsp_data2, 32'h5555_5555);
            check($sformatf("stall%0d_req_ready", c), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("release_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        check("release_read_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("release_rsp_valid", 32'(rsp_valid), 32'd1);
        check("release_rsp_id", 32'(rsp_id), 32'd1);
        check("release_data1", rsp_data1, 32'hAAAA_AAAA);
        check("release_data2", rsp_data2, 32'hFFFF_FFFF);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset while in READ drops the transaction
        do_reset();
        req_rs1   = pk(0, 5, 0, 0);
        req_rs2   = pk(0, 10, 0, 0);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_id", 32'(rsp_id), 32'd0);
        check("midrst_rf_reg1", rf_read_register1, 32'd0);
        check("midrst_rf_reg2", rf_read_register2, 32'd0);
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (c == 2) reset = 1'b0;
            check($sformatf("midrst%0d_no_pulse", c), 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);

        // Only requester 3 with rr_ptr=0: immediate grant, pointer wraps back to 0
        run_vec('{4'b1000, pk(0, 0, 0, 15), pk(0, 0, 0, 10), 4'b1000, 2'd3,
                  32'hFFFF_FFFF, 32'hAAAA_AAAA}, 6);
        run_vec('{4'b1111, pk(5, 0, 0, 0), pk(15, 0, 0, 0), 4'b0001, 2'd0,
                  32'h5555_5555, 32'hFFFF_FFFF}, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
